floating_point_control: RTL

Sequencing controller for the single-precision floating-point datapath: accepts an add/sub/mul request, then drives every datapath control line cycle by cycle. It reads back the datapath status: exponent difference, multiplier done, leading-one distances and rounder overflow. It raises `done` when `resultadoFinal` holds the result. It sits between the CPU FP issue logic and the `floating_point` datapath.

---
 rtl/floating_point_control_if.sv | 68 ++++++
 rtl/floating_point_control.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/floating_point_control_if.sv
// Request/status and datapath control bundle between the FP
// issue logic, the sequencing controller and the FP datapath.
interface floating_point_control_if;
    logic        start;
    logic [1:0]  op;
    logic        signA;
    logic        signB;
    logic [7:0]  smallAluResult;
    logic        endMultiplication;
    logic        rounderOverflow;
    logic [63:0] posFirst27posReferential;
    logic [63:0] posFirst28posReferential;
    logic        loadRegA;
    logic        loadRegB;
    logic        loadRegSmall;
    logic        controlToMux01;
    logic        controlToMux02;
    logic        controlToMux03;
    logic        controlToMux04;
    logic        controlToMux05;
    logic        muxAControlSmall;
    logic        muxBControlSmall;
    logic [3:0]  smallALUOperation;
    logic [7:0]  controlShiftRight;
    logic        isSum;
    logic        sum_sub;
    logic        bigALUReset;
    logic        muxDataRegValor2;
    logic        rightOrLeft;
    logic [22:0] howMany;
    logic        IncreaseOrDecreaseEnable;
    logic [3:0]  controlToIncreaseOrDecrease;
    logic [7:0]  howManyToIncreaseOrDecrease;
    logic        busy;
    logic        done;
    logic        zeroResult;
    logic        error;

    modport slave (
        input  start, op, signA, signB, smallAluResult,
        input  endMultiplication, rounderOverflow,
        input  posFirst27posReferential, posFirst28posReferential,
        output loadRegA, loadRegB, loadRegSmall,
        output controlToMux01, controlToMux02, controlToMux03,
        output controlToMux04, controlToMux05,
        output muxAControlSmall, muxBControlSmall,
        output smallALUOperation, controlShiftRight,
        output isSum, sum_sub, bigALUReset, muxDataRegValor2,
        output rightOrLeft, howMany, IncreaseOrDecreaseEnable,
        output controlToIncreaseOrDecrease, howManyToIncreaseOrDecrease,
        output busy, done, zeroResult, error
    );

    modport master (
        output start, op, signA, signB, smallAluResult,
        output endMultiplication, rounderOverflow,
        output posFirst27posReferential, posFirst28posReferential,
        input  loadRegA, loadRegB, loadRegSmall,
        input  controlToMux01, controlToMux02, controlToMux03,
        input  controlToMux04, controlToMux05,
        input  muxAControlSmall, muxBControlSmall,
        input  smallALUOperation, controlShiftRight,
        input  isSum, sum_sub, bigALUReset, muxDataRegValor2,
        input  rightOrLeft, howMany, IncreaseOrDecreaseEnable,
        input  controlToIncreaseOrDecrease, howManyToIncreaseOrDecrease,
        input  busy, done, zeroResult, error
    );
endinterface

// File: rtl/floating_point_control.sv
// Sequencing FSM for the single-precision add/sub/mul datapath.
// Control lines are decoded from state, latched request and status.
module floating_point_control #(
    parameter int MUL_TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    floating_point_control_if.slave bus
);
    localparam int CW = $clog2(MUL_TIMEOUT + 1);
    localparam logic [63:0] ZERO_CODE = 64'h8000_0000_0000_0000;

    typedef enum logic [3:0] {
        IDLE, LOAD, EXP, ALIGN, MUL_START,
        MUL_WAIT, NORM, ROUND, RENORM, DONE
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q, op_d;
    logic          sign_a_q, sign_a_d;
    logic          sign_b_q, sign_b_d;
    logic          renorm_q, renorm_d;
    logic          zero_q, zero_d;
    logic          err_q, err_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        is_mul;
    logic        d_neg;
    logic [8:0]  d_mag;
    logic [7:0]  shift;
    logic [63:0] p;
    logic [63:0] p_mag;
    logic        p_zero;
    logic        p_neg;
    logic        p_nz;
    logic [22:0] hm_sat;
    logic [7:0]  amt_sat;

    assign is_mul = (op_q == 2'b10);

    // Alignment: magnitude of the exponent difference, capped at 28
    assign d_neg = bus.smallAluResult[7];
    assign d_mag = d_neg ? (9'd256 - {1'b0, bus.smallAluResult})
                         : {1'b0, bus.smallAluResult};
    assign shift = (d_mag > 9'd28) ? 8'd28 : d_mag[7:0];

    assign p      = is_mul ? bus.posFirst28posReferential
                           : bus.posFirst27posReferential;
    assign p_zero = (p == ZERO_CODE);
    assign p_neg  = p[63] & ~p_zero;
    assign p_nz   = (p != 64'd0) & ~p_zero;
    assign p_mag  = p[63] ? (64'd0 - p) : p;
    assign hm_sat = (p_mag > 64'h7F_FFFF) ? 23'h7F_FFFF : p_mag[22:0];
    assign amt_sat = (p_mag > 64'd255) ? 8'hFF : p_mag[7:0];

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        renorm_d = renorm_q;
        zero_d   = zero_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && bus.op != 2'b11) begin
                    op_d     = bus.op;
                    sign_a_d = bus.signA;
                    sign_b_d = bus.signB;
                    renorm_d = 1'b0;
                    zero_d   = 1'b0;
                    err_d    = 1'b0;
                    cnt_d    = '0;
                    state_d  = LOAD;
                end
            end
            LOAD:      state_d = EXP;
            EXP:       state_d = is_mul ? MUL_START : ALIGN;
            ALIGN:     state_d = NORM;
            MUL_START: state_d = MUL_WAIT;
            MUL_WAIT: begin
                if (bus.endMultiplication) begin
                    state_d = NORM;
                end else if (cnt_q == CW'(MUL_TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            NORM: begin
                if (p_zero) begin
                    zero_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    state_d = ROUND;
                end
            end
            // Only one renormalization per operation
            ROUND: begin
                if (bus.rounderOverflow && !renorm_q) state_d = RENORM;
                else                                  state_d = DONE;
            end
            RENORM: begin
                renorm_d = 1'b1;
                state_d  = ROUND;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= 2'b00;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            renorm_q <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            renorm_q <= renorm_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        bus.loadRegA                    = 1'b0;
        bus.loadRegB                    = 1'b0;
        bus.loadRegSmall                = 1'b0;
        bus.controlToMux01              = 1'b0;
        bus.controlToMux02              = 1'b0;
        bus.controlToMux03              = 1'b0;
        bus.controlToMux04              = 1'b0;
        bus.controlToMux05              = 1'b0;
        bus.muxAControlSmall            = 1'b0;
        bus.muxBControlSmall            = 1'b0;
        bus.smallALUOperation           = 4'b0000;
        bus.controlShiftRight           = 8'd0;
        bus.isSum                       = 1'b0;
        bus.sum_sub                     = 1'b0;
        bus.bigALUReset                 = 1'b0;
        bus.muxDataRegValor2            = 1'b0;
        bus.rightOrLeft                 = 1'b0;
        bus.howMany                     = 23'd0;
        bus.IncreaseOrDecreaseEnable    = 1'b0;
        bus.controlToIncreaseOrDecrease = 4'b0000;
        bus.howManyToIncreaseOrDecrease = 8'd0;
        bus.done                        = 1'b0;
        bus.zeroResult                  = 1'b0;
        bus.error                       = 1'b0;
        bus.busy                        = (state_q != IDLE);
        unique case (state_q)
            LOAD: begin
                bus.loadRegA = 1'b1;
                bus.loadRegB = 1'b1;
            end
            EXP: begin
                bus.loadRegSmall      = 1'b1;
                bus.smallALUOperation = is_mul ? 4'b0001 : 4'b0000;
            end
            ALIGN: begin
                bus.controlToMux01    = d_neg;
                bus.controlToMux03    = ~d_neg;
                bus.controlToMux04    = d_neg;
                bus.controlShiftRight = shift;
                bus.isSum             = 1'b1;
                bus.sum_sub = (op_q == 2'b01) ^ sign_a_q ^ sign_b_q;
            end
            MUL_START: begin
                bus.bigALUReset      = 1'b1;
                bus.muxDataRegValor2 = 1'b1;
            end
            NORM: begin
                bus.zeroResult = p_zero;
                if (p_nz) begin
                    bus.rightOrLeft                 = ~p_neg;
                    bus.howMany                     = hm_sat;
                    bus.IncreaseOrDecreaseEnable    = 1'b1;
                    bus.controlToIncreaseOrDecrease = p_neg ? 4'b0001 : 4'b0000;
                    bus.howManyToIncreaseOrDecrease = amt_sat;
                end
            end
            RENORM: begin
                bus.controlToMux05              = 1'b1;
                bus.controlToMux02              = 1'b1;
                bus.rightOrLeft                 = 1'b1;
                bus.howMany                     = 23'd1;
                bus.IncreaseOrDecreaseEnable    = 1'b1;
                bus.howManyToIncreaseOrDecrease = 8'd1;
            end
            DONE: begin
                bus.done       = 1'b1;
                bus.zeroResult = zero_q;
                bus.error      = err_q;
            end
            default: ;
        endcase
    end
endmodule
